// File: rtl/vdecode_pipe_if.sv
// Decode-stage bus: instruction handshake in, decoded control bundle out.
interface vdecode_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         inst;
  logic                out_valid;
  logic                out_ready;
  logic [REG_AW-1:0]   reg_dst;
  logic [REG_AW-1:0]   reg_s;
  logic [REG_AW-1:0]   reg_t;
  logic [DATA_W-1:0]   imm;
  logic [2:0]          alu_op;
  logic                alu_src;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                memtoreg;
  logic                vec;
  logic                illegal;
  logic [STALL_CW-1:0] stall_cnt;

  // Fetch/execute side: drives instructions, consumes bundles.
  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, reg_dst, reg_s, reg_t, imm, alu_op, alu_src,
           reg_write, mem_read, mem_write, memtoreg, vec, illegal, stall_cnt
  );

  // Decode stage side.
  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, reg_dst, reg_s, reg_t, imm, alu_op, alu_src,
           reg_write, mem_read, mem_write, memtoreg, vec, illegal, stall_cnt
  );
endinterface

// File: rtl/vdecode_pipe.sv
// Pipelined scalar/vector instruction decode with load-use hazard stalls.
// One output register (latency 1); a load sitting in it, or one that left
// within the last LOAD_BUBBLES cycles, blocks any instruction reading its
// destination.
module vdecode_pipe #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int STALL_CW     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  vdecode_pipe_if.slave  bus
);

  typedef struct packed {
    logic [REG_AW-1:0] reg_dst;
    logic [REG_AW-1:0] reg_s;
    logic [REG_AW-1:0] reg_t;
    logic [DATA_W-1:0] imm;
    logic [2:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              memtoreg;
    logic              vec;
    logic              illegal;
  } bundle_t;

  bundle_t             bnd_d, bnd_q;
  logic                vld_q;
  logic [1:0]          bub_q;
  logic [REG_AW-1:0]   ldst_q;
  logic [STALL_CW-1:0] stall_q;

  logic [5:0]          op, funct;
  logic [REG_AW-1:0]   rs_w, rt_w, rd_w;
  logic                reads_rt, load_pend, hit_pend, hit_bub, hazard;
  logic                accept, fire;

  assign op    = bus.inst[31:26];
  assign funct = bus.inst[5:0];
  assign rs_w  = REG_AW'(bus.inst[25:21]);
  assign rt_w  = REG_AW'(bus.inst[20:16]);
  assign rd_w  = REG_AW'(bus.inst[15:11]);

  // Decode the incoming word; illegal encodings never write state.
  always_comb begin
    bnd_d       = '0;
    bnd_d.reg_s = rs_w;
    bnd_d.reg_t = rt_w;
    bnd_d.imm   = DATA_W'($signed(bus.inst[15:0]));
    case (op)
      6'h00, 6'h1C: begin
        bnd_d.reg_dst   = rd_w;
        bnd_d.reg_write = 1'b1;
        bnd_d.vec       = (op == 6'h1C);
        case (funct)
          6'h20:   bnd_d.alu_op = 3'd0;
          6'h22:   bnd_d.alu_op = 3'd1;
          6'h24:   bnd_d.alu_op = 3'd2;
          6'h25:   bnd_d.alu_op = 3'd3;
          6'h2A:   bnd_d.alu_op = 3'd4;
          default: bnd_d.illegal = 1'b1;
        endcase
      end
      6'h08: begin
        bnd_d.reg_dst   = rt_w;
        bnd_d.alu_src   = 1'b1;
        bnd_d.reg_write = 1'b1;
      end
      6'h23: begin
        bnd_d.reg_dst   = rt_w;
        bnd_d.alu_src   = 1'b1;
        bnd_d.reg_write = 1'b1;
        bnd_d.mem_read  = 1'b1;
        bnd_d.memtoreg  = 1'b1;
      end
      6'h2B: begin
        bnd_d.alu_src   = 1'b1;
        bnd_d.mem_write = 1'b1;
      end
      default: bnd_d.illegal = 1'b1;
    endcase
    if (bnd_d.illegal) begin
      bnd_d.reg_write = 1'b0;
      bnd_d.mem_read  = 1'b0;
      bnd_d.mem_write = 1'b0;
    end
  end

  // rs is always a source; rt is a source only for R/vector/store formats.
  assign reads_rt  = (op == 6'h00) || (op == 6'h1C) || (op == 6'h2B);
  assign load_pend = vld_q && bnd_q.mem_read;
  assign hit_pend  = load_pend && (bnd_q.reg_dst != '0) &&
                     ((rs_w == bnd_q.reg_dst) || (reads_rt && rt_w == bnd_q.reg_dst));
  assign hit_bub   = (bub_q != 2'd0) && (ldst_q != '0) &&
                     ((rs_w == ldst_q) || (reads_rt && rt_w == ldst_q));
  assign hazard    = hit_pend || hit_bub;

  assign bus.in_ready = !flush && !hazard && (!vld_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = vld_q && bus.out_ready;

  // Output register, load tracking and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnd_q   <= '0;
      vld_q   <= 1'b0;
      bub_q   <= 2'd0;
      ldst_q  <= '0;
      stall_q <= '0;
    end else begin
      if (bus.in_valid && hazard && (stall_q != '1))
        stall_q <= stall_q + STALL_CW'(1);
      if (flush) begin
        vld_q <= 1'b0;
        bub_q <= 2'd0;
      end else begin
        if (accept) begin
          bnd_q <= bnd_d;
          vld_q <= 1'b1;
        end else if (fire) begin
          vld_q <= 1'b0;
        end
        if (fire && load_pend) begin
          ldst_q <= bnd_q.reg_dst;
          bub_q  <= 2'(LOAD_BUBBLES);
        end else if (bub_q != 2'd0) begin
          bub_q <= bub_q - 2'd1;
        end
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.reg_dst   = bnd_q.reg_dst;
  assign bus.reg_s     = bnd_q.reg_s;
  assign bus.reg_t     = bnd_q.reg_t;
  assign bus.imm       = bnd_q.imm;
  assign bus.alu_op    = bnd_q.alu_op;
  assign bus.alu_src   = bnd_q.alu_src;
  assign bus.reg_write = bnd_q.reg_write;
  assign bus.mem_read  = bnd_q.mem_read;
  assign bus.mem_write = bnd_q.mem_write;
  assign bus.memtoreg  = bnd_q.memtoreg;
  assign bus.vec       = bnd_q.vec;
  assign bus.illegal   = bnd_q.illegal;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_vdecode_pipe.sv
// Directed bench for vdecode_pipe with a bundle scoreboard.
module tb_vdecode_pipe;
  localparam int SCW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  vdecode_pipe_if #(.DATA_W(32), .REG_AW(5), .STALL_CW(SCW)) bus ();

  vdecode_pipe #(.DATA_W(32), .REG_AW(5), .LOAD_BUBBLES(1), .STALL_CW(SCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  logic last_acc;
  logic [63:0] sb[$];

  localparam logic [31:0] ADD3 = 32'h00221820;
  localparam logic [31:0] ADDI = 32'h2004FFFB;
  localparam logic [31:0] LW5  = 32'h8C250000;
  localparam logic [31:0] DEP  = 32'h00A23020;
  localparam logic [31:0] IND  = 32'h00E23020;

  // Reference decode, packed as {pad, rd, rs, rt, imm, alu_op, src, rw, mr, mw, m2r, vec, ill}.
  function automatic logic [63:0] model(input logic [31:0] w);
    logic [5:0] op;
    logic [4:0] rd;
    logic [2:0] aop;
    logic src, rw, mr, mw, m2r, vc, ill;
    op = w[31:26];
    rd = 5'd0; aop = 3'd0; src = 0; rw = 0; mr = 0; mw = 0; m2r = 0; vc = 0; ill = 0;
    if (op == 6'h00 || op == 6'h1C) begin
      rd = w[15:11]; rw = 1; vc = (op == 6'h1C);
      if      (w[5:0] == 6'h20) aop = 3'd0;
      else if (w[5:0] == 6'h22) aop = 3'd1;
      else if (w[5:0] == 6'h24) aop = 3'd2;
      else if (w[5:0] == 6'h25) aop = 3'd3;
      else if (w[5:0] == 6'h2A) aop = 3'd4;
      else ill = 1;
    end else if (op == 6'h08) begin
      rd = w[20:16]; src = 1; rw = 1;
    end else if (op == 6'h23) begin
      rd = w[20:16]; src = 1; rw = 1; mr = 1; m2r = 1;
    end else if (op == 6'h2B) begin
      src = 1; mw = 1;
    end else ill = 1;
    if (ill) begin rw = 0; mr = 0; mw = 0; end
    return {7'd0, rd, w[25:21], w[20:16], {{16{w[15]}}, w[15:0]}, aop, src, rw, mr, mw, m2r, vc, ill};
  endfunction

  function automatic logic [63:0] obs();
    return {7'd0, bus.reg_dst, bus.reg_s, bus.reg_t, bus.imm, bus.alu_op, bus.alu_src,
            bus.reg_write, bus.mem_read, bus.mem_write, bus.memtoreg, bus.vec, bus.illegal};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock: settle, score fire/accept, advance to 1 ns past the next edge.
  task automatic cyc();
    logic f, a, fl;
    #2;
    f  = bus.out_valid && bus.out_ready;
    a  = bus.in_valid && bus.in_ready;
    fl = flush;
    if (f) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%h expected=queued_entry", obs());
      end
      if (sb.size() != 0) chk("sb_bundle", obs(), sb.pop_front());
    end
    if (a) begin
      sb.push_back(model(bus.inst));
      n_acc++;
    end
    if (fl) sb.delete();
    last_acc = a;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until accepted (bounded), report stall cycles.
  task automatic send(input logic [31:0] w, output int held);
    bus.in_valid = 1'b1;
    bus.inst     = w;
    held         = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (last_acc) break;
      held++;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 64'(last_acc), 64'd1);
  endtask

  initial begin
    int h, a0;
    logic [63:0] held_bnd;
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.inst = 32'h0; bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_bundle", obs(), 64'd0);
    chk("rst_stall", 64'(bus.stall_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back add then addi.
    bus.out_ready = 1'b1;
    send(ADD3, h);
    chk("b2b_valid0", 64'(bus.out_valid), 64'd1);
    send(ADDI, h);
    chk("b2b_valid1", 64'(bus.out_valid), 64'd1);
    chk("addi_imm", 64'(bus.imm), 64'hFFFFFFFB);
    chk("addi_src", 64'(bus.alu_src), 64'd1);
    chk("addi_dst", 64'(bus.reg_dst), 64'd4);
    cyc(); cyc();

    // Load-use: dependent add stalls through load_pend and one bubble.
    send(LW5, h);
    send(DEP, h);
    chk("lu_held", 64'(h), 64'd2);
    chk("lu_stall", 64'(bus.stall_cnt), 64'd2);
    cyc(); cyc();

    // Independent add after a load: no stall, no gap.
    send(LW5, h);
    send(IND, h);
    chk("ind_held", 64'(h), 64'd0);
    chk("ind_valid", 64'(bus.out_valid), 64'd1);
    chk("ind_stall", 64'(bus.stall_cnt), 64'd2);
    cyc(); cyc(); cyc();

    // Backpressure: output frozen, exactly one accept on release.
    bus.out_ready = 1'b0;
    send(ADD3, h);
    held_bnd = model(ADD3);
    bus.in_valid = 1'b1;
    bus.inst     = ADDI;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      cyc();
      chk("bp_stable", obs(), held_bnd);
    end
    a0 = n_acc;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc(); cyc();
    chk("bp_one_accept", 64'(n_acc - a0), 64'd1);

    // Illegal opcode and vector sub.
    send(32'hFC000000, h);
    chk("ill_flag", 64'(bus.illegal), 64'd1);
    chk("ill_writes", {61'd0, bus.reg_write, bus.mem_read, bus.mem_write}, 64'd0);
    send(32'h70221822, h);
    chk("vec_flag", 64'(bus.vec), 64'd1);
    chk("vec_aluop", 64'(bus.alu_op), 64'd1);
    cyc(); cyc();

    // Flush kills a pending load; dependent goes straight through.
    bus.out_ready = 1'b0;
    send(LW5, h);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    send(DEP, h);
    chk("flush_no_stall", 64'(h), 64'd0);
    chk("flush_stall_kept", 64'(bus.stall_cnt), 64'd2);
    cyc(); cyc();

    // Long stall saturates the counter, then reset mid-stream.
    bus.out_ready = 1'b0;
    send(LW5, h);
    bus.in_valid = 1'b1;
    bus.inst     = DEP;
    for (int i = 0; i < 20; i++) cyc();
    chk("stall_sat", 64'(bus.stall_cnt), 64'hF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_bundle", obs(), 64'd0);
    chk("mid_rst_stall", 64'(bus.stall_cnt), 64'd0);
    sb.delete();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(DEP, h);
    chk("post_rst_no_stall", 64'(h), 64'd0);
    cyc(); cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
